// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream frame source and its FIFO.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
    } src_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Counter width for a range of n values; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rdata.
// Pushes when full and pops when empty are ignored.
module sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream video master: buffers producer pixels and emits one
// FRAME_WIDTH x FRAME_HEIGHT frame per start request, with tuser=SOF and tlast=EOL.
module axis_frame_source
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    localparam int XW = cnt_width(FRAME_WIDTH);
    localparam int YW = cnt_width(FRAME_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    src_state_t            state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                  push;
    logic                  pop;
    logic                  streaming;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign streaming = (state_q == STREAM);
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = m_axis_tvalid && m_axis_tready;

    // tvalid comes only from state and FIFO occupancy, never from tready; the
    // data and sideband bits then stay put while a beat waits for a handshake.
    assign m_axis_tvalid = streaming && !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_rdata : '0;
    assign m_axis_tlast  = m_axis_tvalid && (x_q == X_LAST);
    assign m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
    assign busy          = streaming;
    assign frame_done    = done_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            STREAM: begin
                // An empty FIFO simply withholds the pop, freezing the counters.
                if (pop) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    a_empty_matches_count : assert property (
        @(posedge clk) disable iff (rst) fifo_empty == (fifo_count == '0)
    );

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source (4x2 frame, 4-entry FIFO).
module tb_axis_frame_source;

    localparam int DW    = 16;
    localparam int FW    = 4;
    localparam int FH    = 2;
    localparam int FD    = 4;
    localparam int BEATS = FW * FH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          frame_start = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          tuser;

    int tests = 0;
    int fails = 0;

    axis_frame_source #(
        .DATA_WIDTH   (DW),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pixels leave in push order; beat k of a frame carries
    // tuser when k==0 and tlast when k is the last of its line.
    logic [DW-1:0] exp_q[$];
    int            m_beat = 0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    bit            mon_en = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_user;

    always @(negedge clk) begin : monitor
        bit            nb;
        bit            nd;
        logic [DW-1:0] e;
        if (mon_en) begin
            check("mon_busy", busy, m_busy);
            check("mon_done", frame_done, m_done);
            check("mon_tvalid", tvalid, m_busy && (exp_q.size() != 0));
            check("mon_in_ready", in_ready, exp_q.size() < FD);
            if (prev_hold) begin
                check("hold_tvalid", tvalid, 1);
                check("hold_tdata", tdata, prev_data);
                check("hold_tlast", tlast, prev_last);
                check("hold_tuser", tuser, prev_user);
            end
            nb = m_busy;
            nd = 1'b0;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("mon_pop_on_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_tdata", tdata, e);
                end
                check("mon_tuser", tuser, m_beat == 0);
                check("mon_tlast", tlast, (m_beat % FW) == FW - 1);
                m_beat++;
                if (m_beat == BEATS) begin
                    m_beat = 0;
                    nb = 1'b0;
                    nd = 1'b1;
                end
            end
            if (!m_busy && frame_start) begin
                nb = 1'b1;
                m_beat = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_hold = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
            prev_user = tuser;
            m_busy = nb;
            m_done = nd;
            if (rst) begin
                exp_q.delete();
                m_busy = 1'b0;
                m_done = 1'b0;
                m_beat = 0;
                prev_hold = 1'b0;
            end
        end
    end

    logic [DW-1:0] log_d[$];
    bit            log_u[$];
    bit            log_l[$];
    int            log_c[$];

    task automatic clear_log();
        log_d.delete();
        log_u.delete();
        log_l.delete();
        log_c.delete();
    endtask

    task automatic log_beat(input int c);
        log_d.push_back(tdata);
        log_u.push_back(tuser);
        log_l.push_back(tlast);
        log_c.push_back(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        tready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_n(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = DW'(first + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Streams until frame_done, pushing n_push more pixels as space allows.
    // pat: 0 = tready high, 1 = tready 1,0,0,1 repeating.
    task automatic run_frame(input int next_val, input int n_push, input int pat, input string tag);
        int sent;
        bit got;
        sent = 0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            in_valid = (sent < n_push);
            in_data = DW'(next_val + sent);
            tready = (pat == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            if (in_valid && in_ready) sent++;
            if (tvalid && tready) log_beat(c);
            step();
            if (frame_done) begin
                got = 1'b1;
                check({tag, "_busy_falls"}, busy, 0);
            end
        end
        in_valid = 1'b0;
        tready = 1'b0;
        if (!got) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_log(input int first, input string tag);
        check({tag, "_beats"}, log_d.size(), BEATS);
        for (int i = 0; i < log_d.size() && i < BEATS; i++) begin
            check({tag, "_data"}, log_d[i], DW'(first + i));
            check({tag, "_tuser"}, log_u[i], i == 0);
            check({tag, "_tlast"}, log_l[i], (i % FW) == FW - 1);
        end
    endtask

    typedef struct {
        bit            rst;
        bit            in_valid;
        bit            frame_start;
        bit            tready;
        logic [DW-1:0] data;
        bit            e_tvalid;
        logic [DW-1:0] e_tdata;
        bit            e_tuser;
        bit            e_tlast;
        bit            e_busy;
        bit            e_done;
        bit            e_ready;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int k;
        bit acc;
        int hs;
        int dones;
        int done_c;
        int sent;

        step();
        mon_en = 1'b1;
        do_reset();

        // Underflow, stall, x/y wrap and reset, cycle by cycle.
        tbl[0]  = '{1, 0, 0, 0, 16'h0,  0, 16'h0,  0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 1, 0, 16'h0,  0, 16'h0,  0, 0, 1, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 16'h0,  0, 16'h0,  0, 0, 1, 0, 1};
        tbl[3]  = '{0, 1, 0, 0, 16'h55, 1, 16'h55, 1, 0, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 16'h0,  1, 16'h55, 1, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 1, 16'h56, 1, 16'h56, 0, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 1, 16'h0,  0, 16'h0,  0, 0, 1, 0, 1};
        tbl[7]  = '{0, 1, 0, 1, 16'h57, 1, 16'h57, 0, 0, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 1, 16'h58, 1, 16'h58, 0, 1, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 16'h0,  0, 16'h0,  0, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 1, 16'h59, 1, 16'h59, 0, 0, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 16'h0,  0, 16'h0,  0, 0, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            in_valid = tbl[i].in_valid;
            frame_start = tbl[i].frame_start;
            tready = tbl[i].tready;
            in_data = tbl[i].data;
            step();
            check("vec_tvalid", tvalid, tbl[i].e_tvalid);
            check("vec_tdata", tdata, tbl[i].e_tdata);
            check("vec_tuser", tuser, tbl[i].e_tuser);
            check("vec_tlast", tlast, tbl[i].e_tlast);
            check("vec_busy", busy, tbl[i].e_busy);
            check("vec_done", frame_done, tbl[i].e_done);
            check("vec_in_ready", in_ready, tbl[i].e_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tready = 1'b0;

        // Nominal frame with tready held high.
        do_reset();
        clear_log();
        push_n(0, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_frame(4, 4, 0, "nom");
        check_log(0, "nom");
        step();
        check("nom_done_one_cycle", frame_done, 0);

        // Backpressure.
        do_reset();
        clear_log();
        push_n(0, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_frame(4, 4, 1, "bp");
        check_log(0, "bp");

        // FIFO full in IDLE, then one pop makes room for the held pixel.
        do_reset();
        clear_log();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data = DW'(16'hA0 + k);
            acc = in_ready;
            step();
            if (acc) k++;
        end
        check("full_accepted", k, 4);
        check("full_in_ready", in_ready, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("full_first_tdata", tdata, 16'hA0);
        check("full_still_full", in_ready, 0);
        tready = 1'b1;
        log_beat(0);
        step();
        tready = 1'b0;
        check("full_room_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("full_e_accepted", in_ready, 0);
        run_frame(16'hA5, 3, 0, "full");
        check_log(16'hA0, "full");

        // Reset after three handshakes aborts the frame.
        do_reset();
        push_n(16'h10, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        tready = 1'b1;
        hs = 0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            if (tvalid && tready) hs++;
            step();
        end
        check("rmid_handshakes", hs, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tready = 1'b0;
        check("rmid_tvalid", tvalid, 0);
        check("rmid_busy", busy, 0);
        check("rmid_in_ready", in_ready, 1);
        check("rmid_done", frame_done, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rmid_no_done", frame_done, 0);
        end
        clear_log();
        push_n(16'h20, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_frame(16'h24, 4, 0, "rmid");
        check_log(16'h20, "rmid");

        // Back-to-back frames: a mid-frame start is dropped, one in the done cycle is taken.
        do_reset();
        clear_log();
        push_n(16'h30, 4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        tready = 1'b1;
        dones = 0;
        done_c = -1;
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            if (frame_done) begin
                dones++;
                if (dones == 1) done_c = c;
            end
            frame_start = (c == 3) || (frame_done && dones == 1);
            in_valid = (sent < 12);
            in_data = DW'(16'h34 + sent);
            if (in_valid && in_ready) sent++;
            if (tvalid && tready) log_beat(c);
            step();
        end
        frame_start = 1'b0;
        in_valid = 1'b0;
        tready = 1'b0;
        check("b2b_frames", dones, 2);
        check("b2b_beats", log_d.size(), 2 * BEATS);
        check("b2b_idle_after", busy, 0);
        for (int i = 0; i < log_d.size() && i < 2 * BEATS; i++) begin
            check("b2b_data", log_d[i], DW'(16'h30 + i));
            check("b2b_tuser", log_u[i], (i % BEATS) == 0);
            check("b2b_tlast", log_l[i], (i % FW) == FW - 1);
        end
        if (log_c.size() > BEATS) check("b2b_no_gap", log_c[BEATS], done_c + 1);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_valid = $urandom_range(0, 1);
            in_data = DW'($urandom);
            tready = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        frame_start = 1'b0;
        tready = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream video master. Directly feeds the AXI-Stream slave stage with frame-formatted pixel beats.
- Buffers pixels pushed by a producer in a small synchronous FIFO. Emits exactly one frame of FRAME_WIDTH x FRAME_HEIGHT beats per start request.
- Asserts tuser on the first beat of each frame (start of frame) and tlast on the last beat of each line (end of line).

Parameters:
- DATA_WIDTH, 32, pixel/beat width.
- FRAME_WIDTH, 640, beats per line (>=2).
- FRAME_HEIGHT, 480, lines per frame (>=1).
- FIFO_DEPTH, 8, FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  producer pixel.
- in_valid  in  1  producer pixel valid.
- in_ready  out  1  FIFO can accept; equals !full.
- frame_start  in  1  one-cycle request to emit a frame.
- busy  out  1  high while a frame is being emitted (state STREAM).
- frame_done  out  1  one-cycle pulse after the frame's final handshake.
- m_axis_tdata  out  DATA_WIDTH  beat data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of line.
- m_axis_tuser  out  1  start of frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; state=IDLE; x=0, y=0.
  - Outputs after reset: busy=0, frame_done=0, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, in_ready=1.
  - Reset mid-frame aborts the frame; no frame_done is produced.
- FIFO (show-ahead):
  - push = in_valid && in_ready; pop = m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: data pushed at edge n is visible at the head from cycle n+1.
  - Full: in_ready=0, in_data ignored. Empty: head invalid.
- State machine:
  - IDLE:
    - tvalid=0. FIFO keeps accepting input (prefill allowed).
    - frame_start=1 -> STREAM next cycle with x=0, y=0.
  - STREAM:
    - busy=1; m_axis_tvalid = !empty; tdata = FIFO head.
    - tlast = tvalid && (x==FRAME_WIDTH-1); tuser = tvalid && (x==0 && y==0).
    - On pop: x++; when x==FRAME_WIDTH-1, x wraps to 0 and y++.
    - On pop with x==FRAME_WIDTH-1 && y==FRAME_HEIGHT-1: next state IDLE; frame_done=1 for one cycle; x=y=0.
    - frame_start is ignored in STREAM (not queued).
    - frame_start in the cycle frame_done is high is accepted (back-to-back frames).
- AXI rules:
  - Once tvalid=1 and tready=0, tvalid/tdata/tlast/tuser hold stable until the handshake.
  - tvalid never depends combinationally on tready.
  - Underflow (FIFO empty in STREAM) only stalls the stream: tvalid=0 and the counters hold.
- Counter widths: $clog2(FRAME_WIDTH) and $clog2(FRAME_HEIGHT) bits, unsigned, compare-and-wrap with no overflow.
- Latency:
  - frame_start edge -> tvalid may be high on the next cycle if FIFO is non-empty.
  - Push into empty FIFO during STREAM -> tvalid the next cycle.

Decomposition:
- Package axis_pkg:
  - typedef enum logic [1:0] {IDLE, STREAM} src_state_t.
  - Shared localparam DEFAULT_DATA_WIDTH=32.
- Sub-module sync_fifo:
  - Parameters DATA_WIDTH, DEPTH.
  - Ports clk, rst, push, pop, wdata, rdata, full, empty, count; show-ahead read.
- Top holds the FSM and the x/y counters; tlast/tuser are combinational from the counters.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=2, FIFO_DEPTH=4 unless stated):
- Nominal frame, FIFO_DEPTH=8: push 0..7, pulse frame_start, tready=1 -> 8 beats with data 0..7. tuser only on data 0; tlast on data 3 and 7. frame_done pulses once, the cycle after data 7 handshakes; busy falls with it.
- Backpressure: tready pattern 1,0,0,1 repeating -> while tvalid=1 and tready=0, tdata/tlast/tuser are unchanged. Data order is 0..7, no duplicate or lost beats.
- FIFO full: in IDLE, hold in_valid with data A..E -> in_ready=0 after 4 pushes, E not accepted. After frame_start and one pop, E is accepted next cycle.
- Underflow: frame_start with empty FIFO -> tvalid=0. Push 0x55 at cycle n -> tvalid=1, tdata=0x55, tuser=1 at cycle n+1.
- Reset mid-frame: rst after 3 handshakes -> next cycle tvalid=0, busy=0, in_ready=1, no frame_done. New frame after refill: tuser on first beat, tlast on the 4th.
- Back-to-back frames: frame_start pulsed during STREAM (ignored) and again in the frame_done cycle -> exactly two frames. The second starts with tuser=1 and there is no gap if the FIFO is non-empty.
